// File: rtl/ibufds_sync_filter_pkg.sv
// ---------------------------------------------------------------------------
// ibufds_sync_filter_pkg
// Shared helpers for the differential input receiver slice.
//   cnt_width(n) : bit width of a counter that must hold 0..n-1, never below 1.
// ---------------------------------------------------------------------------
package ibufds_sync_filter_pkg;

  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/ibufds_ibufgds.sv
// ---------------------------------------------------------------------------
// ibufds_ibufgds
// Differential input buffer wrapper. The attributes are carried through so
// a vendor primitive can be dropped in; this body is the behavioural model
// (output follows the positive leg while the pair is complementary).
// Ports:
//   i  : positive pad leg
//   ib : negative pad leg
//   o  : single-ended buffered level
// ---------------------------------------------------------------------------
module ibufds_ibufgds #(
  parameter DIFF_TERM    = "FALSE",
  parameter IBUF_LOW_PWR = "TRUE",
  parameter IOSTANDARD   = "DEFAULT"
) (
  input  logic i,
  input  logic ib,
  output logic o
);

  // A non-complementary pair (both legs equal) reads as 0.
  assign o = i & ~ib;

endmodule

// File: rtl/ibufds_sync_filter_chn.sv
// ---------------------------------------------------------------------------
// ibufds_sync_filter_chn
// One receiver channel: differential buffer, synchroniser into clk, glitch
// filter, registered edge strobes and loss-of-activity watchdog.
// Ports:
//   clk, rst     : clock and asynchronous active-high reset
//   pad_p, pad_n : differential pad pair
//   dout         : filtered, synchronised level
//   rise, fall   : one-cycle strobes, high in the cycle dout shows its new value
//   los          : no strobe seen for 2^LOS_BITS cycles (1 out of reset)
// ---------------------------------------------------------------------------
module ibufds_sync_filter_chn
  import ibufds_sync_filter_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_CNT   = 3,
  parameter int LOS_BITS     = 8,
  parameter     DIFF_TERM    = "FALSE",
  parameter     IBUF_LOW_PWR = "TRUE",
  parameter     IOSTANDARD   = "DEFAULT"
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_p,
  input  logic pad_n,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic los
);

  localparam int unsigned             FCNT_W    = cnt_width(FILTER_CNT);
  localparam logic [FCNT_W-1:0]       FCNT_LAST = FCNT_W'(FILTER_CNT - 1);
  localparam logic [FCNT_W-1:0]       FCNT_ONE  = FCNT_W'(1'b1);
  localparam logic [LOS_BITS-1:0]     LCNT_MAX  = {LOS_BITS{1'b1}};
  localparam logic [LOS_BITS-1:0]     LCNT_ONE  = LOS_BITS'(1'b1);

  logic                   pad_s;
  logic                   s_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic [FCNT_W-1:0]      fcnt_r;
  logic                   dout_r;
  logic                   rise_r;
  logic                   fall_r;
  logic [LOS_BITS-1:0]    lcnt_r;
  logic                   los_r;

  ibufds_ibufgds #(
    .DIFF_TERM    (DIFF_TERM),
    .IBUF_LOW_PWR (IBUF_LOW_PWR),
    .IOSTANDARD   (IOSTANDARD)
  ) u_ibuf (
    .i  (pad_p),
    .ib (pad_n),
    .o  (pad_s)
  );

  assign s_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain; stage 0 is the only flop seeing the asynchronous level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pad_s};
    end
  end

  // Glitch filter: dout follows s only after FILTER_CNT consecutive differing
  // samples; any agreeing sample restarts the count. Strobes fire with the update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_r <= {FCNT_W{1'b0}};
      dout_r <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      if (s_s == dout_r) begin
        fcnt_r <= {FCNT_W{1'b0}};
        rise_r <= 1'b0;
        fall_r <= 1'b0;
      end else if (fcnt_r == FCNT_LAST) begin
        fcnt_r <= {FCNT_W{1'b0}};
        dout_r <= s_s;
        rise_r <= s_s;
        fall_r <= ~s_s;
      end else begin
        fcnt_r <= fcnt_r + FCNT_ONE;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
      end
    end
  end

  // Activity watchdog: a visible strobe clears it; otherwise count up and
  // saturate, raising los once the counter has reached all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcnt_r <= {LOS_BITS{1'b0}};
      los_r  <= 1'b1;
    end else begin
      if (rise_r | fall_r) begin
        lcnt_r <= {LOS_BITS{1'b0}};
        los_r  <= 1'b0;
      end else if (lcnt_r == LCNT_MAX) begin
        los_r  <= 1'b1;
      end else begin
        lcnt_r <= lcnt_r + LCNT_ONE;
      end
    end
  end

  assign dout = dout_r;
  assign rise = rise_r;
  assign fall = fall_r;
  assign los  = los_r;

endmodule

// File: rtl/ibufds_sync_filter.sv
// ---------------------------------------------------------------------------
// ibufds_sync_filter
// Multi-channel differential input receiver for slow asynchronous board
// signals. Each channel is independent (see ibufds_sync_filter_chn).
// Ports:
//   clk, rst     : clock and asynchronous active-high reset
//   din_p, din_n : differential pad legs, one pair per channel
//   dout         : filtered, synchronised levels
//   rise, fall   : one-cycle edge strobes on dout
//   los          : per-channel loss-of-activity flags (all 1s out of reset)
// ---------------------------------------------------------------------------
module ibufds_sync_filter #(
  parameter int WIDTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_CNT   = 3,
  parameter int LOS_BITS     = 8,
  parameter     DIFF_TERM    = "FALSE",
  parameter     IBUF_LOW_PWR = "TRUE",
  parameter     IOSTANDARD   = "DEFAULT"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_p,
  input  logic [WIDTH-1:0] din_n,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] los
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chn
    ibufds_sync_filter_chn #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CNT   (FILTER_CNT),
      .LOS_BITS     (LOS_BITS),
      .DIFF_TERM    (DIFF_TERM),
      .IBUF_LOW_PWR (IBUF_LOW_PWR),
      .IOSTANDARD   (IOSTANDARD)
    ) u_chn (
      .clk   (clk),
      .rst   (rst),
      .pad_p (din_p[gi]),
      .pad_n (din_n[gi]),
      .dout  (dout[gi]),
      .rise  (rise[gi]),
      .fall  (fall[gi]),
      .los   (los[gi])
    );
  end

endmodule

// File: tb/tb_ibufds_sync_filter.sv
// ---------------------------------------------------------------------------
// tb_ibufds_sync_filter
// Drives pad patterns one clock at a time. A reference model, written from
// the pad history (three consecutive differing synchronised samples flip the
// level; los is "no strobe yet, or 16+ quiet edges since one"), pushes the
// expected outputs into a queue; they are popped and compared on the
// following falling edge.
// ---------------------------------------------------------------------------
module tb_ibufds_sync_filter;

  localparam int W   = 4;
  localparam int LOS = 16;

  typedef struct packed {
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] los;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] din_p;
  logic [W-1:0] din_n;
  logic [W-1:0] dout;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] los;

  int n_checks;
  int n_fail;

  exp_t exp_q[$];

  // reference model state
  logic [W-1:0] m_st0, m_st1;
  logic [W-1:0] m_h0, m_h1, m_h2;
  logic [W-1:0] m_dout, m_rise, m_fall, m_seen;
  int           m_idle [W];
  logic [W-1:0] pads;

  ibufds_sync_filter #(
    .WIDTH        (W),
    .SYNC_STAGES  (2),
    .FILTER_CNT   (3),
    .LOS_BITS     (4),
    .DIFF_TERM    ("FALSE"),
    .IBUF_LOW_PWR ("TRUE"),
    .IOSTANDARD   ("DEFAULT")
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .din_p (din_p),
    .din_n (din_n),
    .dout  (dout),
    .rise  (rise),
    .fall  (fall),
    .los   (los)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st0 = '0; m_st1 = '0;
    m_h0 = '0; m_h1 = '0; m_h2 = '0;
    m_dout = '0; m_rise = '0; m_fall = '0; m_seen = '0;
    for (int c = 0; c < W; c++) m_idle[c] = 0;
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'h0);
    chk({tag, "_rise"}, 32'(rise), 32'h0);
    chk({tag, "_fall"}, 32'(fall), 32'h0);
    chk({tag, "_los"},  32'(los),  32'hF);
  endtask

  // Drive one cycle of pad values, model the edge, compare on the negedge.
  task automatic step(input logic [W-1:0] p);
    exp_t         e;
    logic [W-1:0] strobe_v;
    din_p = p;
    din_n = ~p;
    @(posedge clk);
    strobe_v = m_rise | m_fall;
    m_h2 = m_h1; m_h1 = m_h0; m_h0 = m_st1;
    for (int c = 0; c < W; c++) begin
      if (strobe_v[c]) begin
        m_seen[c] = 1'b1;
        m_idle[c] = 0;
      end else if (m_idle[c] < LOS) begin
        m_idle[c]++;
      end
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (m_h0[c] != m_dout[c] && m_h1[c] != m_dout[c] && m_h2[c] != m_dout[c]) begin
        m_dout[c] = m_h0[c];
        m_rise[c] = m_h0[c];
        m_fall[c] = ~m_h0[c];
      end
    end
    m_st1 = m_st0;
    m_st0 = p;
    e.dout = m_dout;
    e.rise = m_rise;
    e.fall = m_fall;
    for (int c = 0; c < W; c++) e.los[c] = !m_seen[c] || (m_idle[c] >= LOS);
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      chk("dout", 32'(dout), 32'(e.dout));
      chk("rise", 32'(rise), 32'(e.rise));
      chk("fall", 32'(fall), 32'(e.fall));
      chk("los",  32'(los),  32'(e.los));
      chk("rise_and_fall", 32'(rise & fall), 32'h0);
    end
  endtask

  task automatic hold(input logic [W-1:0] p, input int n);
    for (int k = 0; k < n; k++) step(p);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pads     = '0;
    din_p    = '0;
    din_n    = '1;
    rst      = 1'b1;
    model_reset();

    // reset with pads quiet
    #1;
    chk_reset_vals("rst_early");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst_held");
    rst = 1'b0;
    hold(4'b0000, 4);

    // ch0 rises and is held; los[0] later times out
    hold(4'b0001, 8);
    hold(4'b0001, 20);

    // ch1 glitches of 2 and 1 cycles, then a real 3-cycle pulse
    hold(4'b0011, 2);
    hold(4'b0001, 4);
    hold(4'b0011, 1);
    hold(4'b0001, 4);
    hold(4'b0011, 3);
    hold(4'b0001, 10);

    // quiet long enough for every channel to report los
    hold(4'b0001, 24);

    // all channels toggle together, then back
    hold(4'b1110, 10);
    hold(4'b0001, 10);

    // reset while ch2 is mid-filter with its pad held high
    hold(4'b0000, 8);
    hold(4'b0100, 3);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst_mid_held");
    rst = 1'b0;
    hold(4'b0100, 10);

    // random pad activity with glitches of assorted lengths
    pads = 4'b0100;
    for (int k = 0; k < 300; k++) begin
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(3, 0) == 0) pads[c] = ~pads[c];
      end
      step(pads);
    end
    hold(pads, 25);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
